// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit stream: FSM state encoding,
// parity mode constants and the frame-length calculation.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   // Number of baud ticks one complete frame occupies on the line.
   function automatic int frame_len(input int data_bits, input int parity, input int stop_bits);
      return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO: the head word is always visible on
// rd_data while the FIFO is non-empty; pushes into a full FIFO are ignored.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: rtl/uart_tx_stream.sv
// UART transmitter fed by a FIFO: frames start/data/parity/stop bits onto tx,
// advancing one bit per baud_tick and chaining queued words with no idle gap.
module uart_tx_stream
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          baud_tick,
   input  logic [DATA_BITS-1:0]          in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int CW        = $clog2(FIFO_DEPTH) + 1;
   localparam int FRAME_LEN = frame_len(DATA_BITS, PARITY, STOP_BITS);
   localparam int BCW       = $clog2(FRAME_LEN + 1);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $fatal(1, "uart_tx_stream: DATA_BITS must be 5..9");
   end
   if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
      $fatal(1, "uart_tx_stream: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $fatal(1, "uart_tx_stream: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $fatal(1, "uart_tx_stream: FIFO_DEPTH must be a power of two in 2..256");
   end

   uart_state_e          state_q, state_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [1:0]           stop_cnt_q, stop_cnt_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;

   logic [DATA_BITS-1:0] head;
   logic [CW-1:0]        count;
   logic                 fifo_full, fifo_empty;
   logic                 pop, last_data, last_stop;

   uart_tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (in_valid && in_ready),
      .wr_data (in_data),
      .pop     (pop),
      .rd_data (head),
      .count   (count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign in_ready   = !fifo_full;
   assign fifo_count = count;
   assign tx         = tx_q;
   assign busy       = (state_q != ST_IDLE) || (count != '0);

   // bit_cnt counts data bits already placed on the line.
   assign last_data = (bit_cnt_q == BCW'(DATA_BITS));
   assign last_stop = (stop_cnt_q == 2'(STOP_BITS));
   assign pop = baud_tick && !fifo_empty &&
                ((state_q == ST_IDLE) || (state_q == ST_STOP && last_stop));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= '0;
         par_q      <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         par_q      <= par_d;
         tx_q       <= tx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (baud_tick) begin
         unique case (state_q)
            ST_IDLE:   if (!fifo_empty) state_d = ST_START;
            ST_START:  state_d = ST_DATA;
            ST_DATA:   if (last_data) state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: state_d = ST_STOP;
            ST_STOP:   if (last_stop) state_d = fifo_empty ? ST_IDLE : ST_START;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      par_d      = par_q;
      tx_d       = tx_q;
      if (pop) begin
         // Parity is latched at load so the shift register can be consumed freely.
         shreg_d   = head;
         par_d     = (^head) ^ (PARITY == PAR_ODD);
         bit_cnt_d = '0;
         tx_d      = 1'b0;
      end else if (baud_tick) begin
         unique case (state_q)
            ST_START: begin
               tx_d      = shreg_q[0];
               shreg_d   = shreg_q >> 1;
               bit_cnt_d = BCW'(1);
            end
            ST_DATA: begin
               if (last_data) begin
                  if (PARITY != PAR_NONE) begin
                     tx_d = par_q;
                  end else begin
                     tx_d       = 1'b1;
                     stop_cnt_d = 2'd1;
                  end
               end else begin
                  tx_d      = shreg_q[0];
                  shreg_d   = shreg_q >> 1;
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
            ST_PARITY: begin
               tx_d       = 1'b1;
               stop_cnt_d = 2'd1;
            end
            ST_STOP: begin
               tx_d = 1'b1;
               if (!last_stop) stop_cnt_d = stop_cnt_q + 1'b1;
            end
            default: tx_d = 1'b1;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Scoreboard bench for uart_tx_stream: four parameterisations, expected frames
// queued at push time and compared by per-instance line monitors.
module tb_uart_tx_stream;

   localparam int FLEN [4] = '{10, 10, 10, 11};

   logic       clk, rst, baud_tick;
   logic [8:0] din   [4];
   logic       vld   [4];
   logic       rdyw  [4];
   logic       txw   [4];
   logic       busyw [4];
   logic [4:0] cnt_a, cnt_b, cnt_c;
   logic [2:0] cnt_d;

   logic [15:0] exp_q   [4][$];
   int          start_q [4][$];
   int          checks;
   int          errors;
   int          tick_cnt;
   logic        tick_d1;
   bit          tick_en;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   uart_tx_stream #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_a (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .in_data(din[0][7:0]), .in_valid(vld[0]),
      .in_ready(rdyw[0]), .tx(txw[0]), .busy(busyw[0]), .fifo_count(cnt_a));
   uart_tx_stream #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u_b (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .in_data(din[1][6:0]), .in_valid(vld[1]),
      .in_ready(rdyw[1]), .tx(txw[1]), .busy(busyw[1]), .fifo_count(cnt_b));
   uart_tx_stream #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u_c (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .in_data(din[2][6:0]), .in_valid(vld[2]),
      .in_ready(rdyw[2]), .tx(txw[2]), .busy(busyw[2]), .fifo_count(cnt_c));
   uart_tx_stream #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_d (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .in_data(din[3][7:0]), .in_valid(vld[3]),
      .in_ready(rdyw[3]), .tx(txw[3]), .busy(busyw[3]), .fifo_count(cnt_d));

   // One tick every 4 clocks while enabled.
   initial begin
      int div;
      div = 0;
      baud_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (tick_en) begin
            div = (div + 1) % 4;
            baud_tick = (div == 0);
         end else begin
            div = 0;
            baud_tick = 1'b0;
         end
      end
   end

   initial begin
      tick_cnt = 0;
      tick_d1  = 1'b0;
   end
   always @(posedge clk) begin
      tick_d1 <= baud_tick;
      if (baud_tick) tick_cnt <= tick_cnt + 1;
   end

   // Line monitors: detect a start bit, collect the frame, compare with the queue head.
   genvar gi;
   for (gi = 0; gi < 4; gi++) begin : g_mon
      initial begin
         logic [15:0] want;
         logic [15:0] got;
         int          n;
         bit          active;
         active = 1'b0;
         want = '0;
         got = '0;
         n = 0;
         forever begin
            @(negedge clk);
            if (rst) begin
               active = 1'b0;
            end else if (tick_d1) begin
               if (!active) begin
                  if (txw[gi] == 1'b0) begin
                     start_q[gi].push_back(tick_cnt);
                     if (exp_q[gi].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame inst %0d: start bit at tick %0d, required idle line",
                                 gi, tick_cnt);
                     end else begin
                        want   = exp_q[gi].pop_front();
                        got    = '0;
                        n      = 1;
                        active = 1'b1;
                     end
                  end
               end else begin
                  got[n] = txw[gi];
                  n++;
                  if (n == FLEN[gi]) begin
                     active = 1'b0;
                     checks++;
                     if (got != want) begin
                        errors++;
                        $display("FAIL frame inst %0d: actual bits 0x%h required 0x%h", gi, got, want);
                     end else begin
                        $display("frame inst %0d: bits 0x%h ok", gi, got);
                     end
                  end
               end
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push1(input int idx, input logic [8:0] d, input bit expect_frame, input logic [15:0] bits);
      vld[idx] = 1'b1;
      din[idx] = d;
      if (expect_frame) exp_q[idx].push_back(bits);
      step();
      vld[idx] = 1'b0;
   endtask

   task automatic wait_drain(input int idx, input int max_cyc);
      int i;
      for (i = 0; i < max_cyc; i++) begin
         if (exp_q[idx].size() == 0 && busyw[idx] == 1'b0) break;
         step();
      end
      checks++;
      if (i == max_cyc) begin
         errors++;
         $display("FAIL drain_timeout inst %0d: %0d frames pending after %0d cycles, required 0",
                  idx, exp_q[idx].size(), max_cyc);
         exp_q[idx].delete();
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n0;
      int n1;
      int t_push;
      int guard;
      int seen;
      checks = 0;
      errors = 0;
      tick_en = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vld[i] = 1'b0;
         din[i] = '0;
      end
      repeat (3) step();

      chk("reset_a_tx", txw[0], 1);
      chk("reset_a_busy", busyw[0], 0);
      chk("reset_a_ready", rdyw[0], 1);
      chk("reset_a_count", cnt_a, 0);
      chk("reset_d_tx", txw[3], 1);
      chk("reset_d_busy", busyw[3], 0);
      chk("reset_d_ready", rdyw[3], 1);
      chk("reset_d_count", cnt_d, 0);

      rst = 1'b0;
      step();
      tick_en = 1'b1;

      // Default frame of 0x48.
      push1(0, 9'h48, 1'b1, 16'h0290);
      chk("a_count_after_push", cnt_a, 1);
      chk("a_busy_after_push", busyw[0], 1);
      wait_drain(0, 200);
      chk("a_idle_high", txw[0], 1);

      // All-zero, all-one and mixed words queued back-to-back.
      push1(0, 9'h00, 1'b1, 16'h0200);
      push1(0, 9'hFF, 1'b1, 16'h03FE);
      push1(0, 9'hA5, 1'b1, 16'h034A);
      wait_drain(0, 400);

      // 7 data bits, even then odd parity.
      push1(1, 9'h41, 1'b1, 16'h0282);
      push1(2, 9'h41, 1'b1, 16'h0382);
      wait_drain(1, 200);
      wait_drain(2, 200);

      // Two stop bits, back-to-back frames with no idle gap.
      start_q[3].delete();
      push1(3, 9'h55, 1'b1, 16'h06AA);
      push1(3, 9'hAA, 1'b1, 16'h0754);
      wait_drain(3, 400);
      chk("d_start_count", start_q[3].size(), 2);
      if (start_q[3].size() == 2) chk("d_frame_spacing", start_q[3][1] - start_q[3][0], 11);

      // Fill the depth-4 FIFO with ticks stopped; words 5 and 6 must be dropped.
      tick_en = 1'b0;
      repeat (4) step();
      push1(3, 9'h01, 1'b1, 16'h0602);
      push1(3, 9'h02, 1'b1, 16'h0604);
      push1(3, 9'h03, 1'b1, 16'h0606);
      chk("d_count_3", cnt_d, 3);
      chk("d_ready_3", rdyw[3], 1);
      push1(3, 9'h04, 1'b1, 16'h0608);
      chk("d_count_full", cnt_d, 4);
      chk("d_ready_full", rdyw[3], 0);
      push1(3, 9'h05, 1'b0, 16'h0000);
      push1(3, 9'h06, 1'b0, 16'h0000);
      chk("d_count_after_drop", cnt_d, 4);
      chk("d_busy_full", busyw[3], 1);
      tick_en = 1'b1;
      wait_drain(3, 1000);

      // Push coinciding with an idle tick: start bit must wait for the next tick.
      guard = 0;
      while (!baud_tick && guard < 20) begin
         step();
         guard++;
      end
      chk("tick_align", baud_tick, 1);
      n0 = start_q[0].size();
      push1(0, 9'h3C, 1'b1, 16'h0278);
      t_push = tick_cnt;
      wait_drain(0, 200);
      chk("a_start_after_push", start_q[0].size(), n0 + 1);
      if (start_q[0].size() == n0 + 1) chk("a_start_tick", start_q[0][n0], t_push + 1);

      // Reset during data bit 3 with two more words queued.
      n0 = start_q[0].size();
      push1(0, 9'h11, 1'b1, 16'h0222);
      push1(0, 9'h22, 1'b1, 16'h0244);
      push1(0, 9'h33, 1'b1, 16'h0266);
      guard = 0;
      while (start_q[0].size() == n0 && guard < 50) begin
         step();
         guard++;
      end
      chk("a_frame_started", start_q[0].size(), n0 + 1);
      seen = 0;
      guard = 0;
      while (seen < 4 && guard < 40) begin
         step();
         if (tick_d1) seen++;
         guard++;
      end
      step();
      chk("a_bit3_low", txw[0], 0);
      rst = 1'b1;
      #1;
      chk("rst_async_tx", txw[0], 1);
      chk("rst_count", cnt_a, 0);
      chk("rst_busy", busyw[0], 0);
      chk("rst_ready", rdyw[0], 1);
      exp_q[0].delete();
      step();
      repeat (3) step();
      rst = 1'b0;
      n1 = start_q[0].size();
      repeat (60) step();
      chk("no_frame_after_reset", start_q[0].size(), n1);
      chk("idle_after_reset_tx", txw[0], 1);
      chk("idle_after_reset_busy", busyw[0], 0);
      push1(0, 9'h48, 1'b1, 16'h0290);
      wait_drain(0, 200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
